// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the parametrised FWFT FIFO.
package fifo_pkg;

   localparam int CRC_DATA_W = 8;
   localparam int CRC_DEPTH  = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int p = 1; p < v; p = p * 2) r++;
      return r;
   endfunction

   // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 states.
   function automatic int cw_of(input int depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer register; wraps DEPTH-1 -> 0 explicitly so any DEPTH works.
module fifo_ptr_wrap
   import fifo_pkg::*;
#(
   parameter int DEPTH = CRC_DEPTH,
   parameter int PW    = clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [PW-1:0] o_ptr
);

   logic [PW-1:0] r_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         if (r_ptr == PW'(DEPTH - 1)) r_ptr <= '0;
         else                         r_ptr <= r_ptr + PW'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_fwft_param.sv
// First-word-fall-through FIFO with thresholds, free count, sticky error flags
// and high-water mark; feeds the CRC32 engine from the bus write path.
module fifo_fwft_param
   import fifo_pkg::*;
#(
   parameter  int DATA_W   = CRC_DATA_W,
   parameter  int DEPTH    = CRC_DEPTH,
   parameter  int AF_LEVEL = DEPTH - 1,
   parameter  int AE_LEVEL = 1,
   localparam int CW       = cw_of(DEPTH)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              almost_full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              almost_empty,
   output logic [CW-1:0]     count,
   output logic [CW-1:0]     free,
   output logic [CW-1:0]     hwm,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int PW = clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     r_hwm;
   logic              r_overflow;
   logic              r_underflow;

   logic [PW-1:0]     w_wptr;
   logic [PW-1:0]     w_rptr;
   logic              w_empty;
   logic              w_full;
   logic              w_do_rd;
   logic              w_do_wr;
   logic              w_wr_step;
   logic              w_rd_step;
   logic              w_ovf_set;
   logic              w_unf_set;
   logic [CW-1:0]     w_next_count;
   logic [CW-1:0]     w_next_hwm;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_do_rd   = rd_en & ~w_empty;
   assign w_do_wr   = wr_en & (~w_full | w_do_rd);
   // flush discards the cycle's requests entirely, including their flag effects
   assign w_wr_step = w_do_wr & ~flush;
   assign w_rd_step = w_do_rd & ~flush;
   assign w_ovf_set = wr_en & ~w_do_wr & ~flush;
   assign w_unf_set = rd_en & w_empty & ~flush;

   fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (flush),
      .i_inc (w_wr_step),
      .o_ptr (w_wptr)
   );

   fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rptr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (flush),
      .i_inc (w_rd_step),
      .o_ptr (w_rptr)
   );

   always_ff @(posedge clk) begin
      if (w_wr_step) r_mem[w_wptr] <= din;
   end

   always_comb begin
      w_next_count = r_count;
      if (flush)                       w_next_count = '0;
      else if (w_do_wr && !w_do_rd)    w_next_count = r_count + CW'(1);
      else if (!w_do_wr && w_do_rd)    w_next_count = r_count - CW'(1);
   end

   always_comb begin
      w_next_hwm = r_hwm;
      if (clr_err)                     w_next_hwm = w_next_count;
      else if (w_next_count > r_hwm)   w_next_hwm = w_next_count;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_hwm       <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_next_count;
         r_hwm       <= w_next_hwm;
         r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
         r_underflow <= w_unf_set | (r_underflow & ~clr_err);
      end
   end

   assign dout         = w_empty ? '0 : r_mem[w_rptr];
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_full  = (r_count >= CW'(AF_LEVEL));
   assign almost_empty = (r_count <= CW'(AE_LEVEL));
   assign count        = r_count;
   assign free         = CW'(DEPTH) - r_count;
   assign hwm          = r_hwm;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_fwft_param.sv
// Bench for fifo_fwft_param: directed vector table, corner sequences and a
// queue-based reference model checking three configurations every cycle.
module tb_fifo_fwft_param;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       wr  [3];
   logic       rd  [3];
   logic       fl  [3];
   logic       clr [3];
   logic [7:0] di  [3];

   logic       a_full, a_af, a_empty, a_ae, a_ov, a_un;
   logic [7:0] a_dout;
   logic [3:0] a_count, a_free, a_hwm;
   logic       b_full, b_af, b_empty, b_ae, b_ov, b_un;
   logic [7:0] b_dout;
   logic [2:0] b_count, b_free, b_hwm;
   logic       c_full, c_af, c_empty, c_ae, c_ov, c_un;
   logic [7:0] c_dout;
   logic [3:0] c_count, c_free, c_hwm;

   fifo_fwft_param u_a (
      .clk(clk), .rst_n(rst_n), .flush(fl[0]), .wr_en(wr[0]), .din(di[0]),
      .full(a_full), .almost_full(a_af), .rd_en(rd[0]), .dout(a_dout),
      .empty(a_empty), .almost_empty(a_ae), .count(a_count), .free(a_free),
      .hwm(a_hwm), .overflow(a_ov), .underflow(a_un), .clr_err(clr[0])
   );

   fifo_fwft_param #(.DATA_W(8), .DEPTH(5)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(fl[1]), .wr_en(wr[1]), .din(di[1]),
      .full(b_full), .almost_full(b_af), .rd_en(rd[1]), .dout(b_dout),
      .empty(b_empty), .almost_empty(b_ae), .count(b_count), .free(b_free),
      .hwm(b_hwm), .overflow(b_ov), .underflow(b_un), .clr_err(clr[1])
   );

   fifo_fwft_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(fl[2]), .wr_en(wr[2]), .din(di[2]),
      .full(c_full), .almost_full(c_af), .rd_en(rd[2]), .dout(c_dout),
      .empty(c_empty), .almost_empty(c_ae), .count(c_count), .free(c_free),
      .hwm(c_hwm), .overflow(c_ov), .underflow(c_un), .clr_err(clr[2])
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: contents as a queue, flags/hwm as plain variables
   int         MD  [3] = '{8, 5, 8};
   int         MAF [3] = '{7, 4, 6};
   int         MAE [3] = '{1, 1, 2};
   logic [7:0] mq  [3][$];
   int         mh  [3];
   bit         mov [3];
   bit         mun [3];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input int i);
      int sz;
      bit rok, wok, ovs, uns;
      if (!rst_n) begin
         mq[i].delete();
         mh[i] = 0; mov[i] = 0; mun[i] = 0;
         return;
      end
      ovs = 0; uns = 0;
      if (fl[i]) begin
         mq[i].delete();
      end else begin
         sz  = mq[i].size();
         rok = rd[i] && sz > 0;
         wok = wr[i] && (sz < MD[i] || rok);
         ovs = wr[i] && !wok;
         uns = rd[i] && sz == 0;
         if (rok) void'(mq[i].pop_front());
         if (wok) mq[i].push_back(di[i]);
      end
      mov[i] = ovs || (mov[i] && !clr[i]);
      mun[i] = uns || (mun[i] && !clr[i]);
      sz = mq[i].size();
      mh[i] = clr[i] ? sz : ((sz > mh[i]) ? sz : mh[i]);
   endtask

   task automatic cmp(input int i);
      int ad, ac, afr, ah, sz, ed;
      bit f, af, e, ae, ov, un;
      case (i)
         0: begin ad = a_dout; ac = a_count; afr = a_free; ah = a_hwm;
                  f = a_full; af = a_af; e = a_empty; ae = a_ae; ov = a_ov; un = a_un; end
         1: begin ad = b_dout; ac = b_count; afr = b_free; ah = b_hwm;
                  f = b_full; af = b_af; e = b_empty; ae = b_ae; ov = b_ov; un = b_un; end
         default: begin ad = c_dout; ac = c_count; afr = c_free; ah = c_hwm;
                  f = c_full; af = c_af; e = c_empty; ae = c_ae; ov = c_ov; un = c_un; end
      endcase
      sz = mq[i].size();
      ed = (sz > 0) ? int'(mq[i][0]) : 0;
      chk($sformatf("u%0d.dout", i),  ad,  ed);
      chk($sformatf("u%0d.count", i), ac,  sz);
      chk($sformatf("u%0d.free", i),  afr, MD[i] - sz);
      chk($sformatf("u%0d.hwm", i),   ah,  mh[i]);
      chk($sformatf("u%0d.full", i),  int'(f),  int'(sz == MD[i]));
      chk($sformatf("u%0d.empty", i), int'(e),  int'(sz == 0));
      chk($sformatf("u%0d.afull", i), int'(af), int'(sz >= MAF[i]));
      chk($sformatf("u%0d.aempty", i), int'(ae), int'(sz <= MAE[i]));
      chk($sformatf("u%0d.overflow", i), int'(ov), int'(mov[i]));
      chk($sformatf("u%0d.underflow", i), int'(un), int'(mun[i]));
   endtask

   // inputs change only at negedge; model advances at posedge, compare at negedge
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < 3; i++) cmp(i);
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) begin
         wr[i] = 0; rd[i] = 0; fl[i] = 0; clr[i] = 0; di[i] = '0;
      end
   endtask

   typedef struct {
      logic       wr, rd, fl, clr;
      logic [7:0] din;
      int         cnt;
      int         dout;
      bit         full, empty, ov, un;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic r, input logic f, input logic c,
                               input logic [7:0] d, input int cnt, input int dout,
                               input bit full, input bit empty, input bit ov, input bit un);
      vec_t v;
      v.wr = w; v.rd = r; v.fl = f; v.clr = c; v.din = d;
      v.cnt = cnt; v.dout = dout; v.full = full; v.empty = empty; v.ov = ov; v.un = un;
      return v;
   endfunction

   vec_t       tv [$];
   logic [7:0] drain [8] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hA5};
   logic [7:0] got [$];
   int         sent;

   initial begin
      idle_all();
      rst_n = 1'b0;
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;

      // --- directed vector table on the default DEPTH=8 instance ---
      tv.push_back(mk(0,0,0,0, 8'h00, 0, 8'h00, 0,1,0,0));
      for (int k = 1; k <= 8; k++)
         tv.push_back(mk(1,0,0,0, 8'(k * 17), k, 8'h11, k == 8, 0, 0, 0));
      tv.push_back(mk(1,0,0,0, 8'h99, 8, 8'h11, 1,0,1,0));
      tv.push_back(mk(1,1,0,0, 8'hA5, 8, 8'h22, 1,0,1,0));
      for (int j = 1; j <= 7; j++)
         tv.push_back(mk(0,1,0,0, 8'h00, 8 - j, drain[j], 0,0,1,0));
      tv.push_back(mk(0,1,0,0, 8'h00, 0, 8'h00, 0,1,1,0));
      tv.push_back(mk(0,1,0,0, 8'h00, 0, 8'h00, 0,1,1,1));
      tv.push_back(mk(0,0,0,1, 8'h00, 0, 8'h00, 0,1,0,0));
      tv.push_back(mk(1,1,0,0, 8'h5A, 1, 8'h5A, 0,0,0,1));
      tv.push_back(mk(0,1,0,1, 8'h00, 0, 8'h00, 0,1,0,0));

      for (int n = 0; n < tv.size(); n++) begin
         wr[0] = tv[n].wr; rd[0] = tv[n].rd; fl[0] = tv[n].fl; clr[0] = tv[n].clr;
         di[0] = tv[n].din;
         tick();
         chk($sformatf("tv%0d.count", n), int'(a_count), tv[n].cnt);
         chk($sformatf("tv%0d.dout", n),  int'(a_dout),  tv[n].dout);
         chk($sformatf("tv%0d.full", n),  int'(a_full),  int'(tv[n].full));
         chk($sformatf("tv%0d.empty", n), int'(a_empty), int'(tv[n].empty));
         chk($sformatf("tv%0d.ovf", n),   int'(a_ov),    int'(tv[n].ov));
         chk($sformatf("tv%0d.unf", n),   int'(a_un),    int'(tv[n].un));
      end
      idle_all();

      // --- thresholds and flush on the AF=6/AE=2 instance ---
      for (int k = 1; k <= 6; k++) begin
         wr[2] = 1; di[2] = 8'(8'hC0 + k);
         tick();
         chk($sformatf("thr.afull@%0d", k),  int'(c_af), int'(k >= 6));
         chk($sformatf("thr.aempty@%0d", k), int'(c_ae), int'(k <= 2));
      end
      chk("thr.hwm", int'(c_hwm), 6);
      wr[2] = 1; fl[2] = 1; di[2] = 8'hFF;
      tick();
      chk("flush.count", int'(c_count), 0);
      chk("flush.empty", int'(c_empty), 1);
      chk("flush.dout",  int'(c_dout),  0);
      chk("flush.hwm",   int'(c_hwm),   6);
      chk("flush.ovf",   int'(c_ov),    0);
      wr[2] = 0; rd[2] = 1;
      tick();
      chk("flush.unf", int'(c_un), 0);
      idle_all();
      tick();

      // --- DEPTH=5 stream: 20 bytes, never overfilled, order must survive wraps ---
      sent = 0;
      for (int k = 0; k < 200 && got.size() < 20; k++) begin
         rd[1] = k[0];
         wr[1] = (sent < 20) && (mq[1].size() < 5 || (rd[1] && mq[1].size() > 0));
         di[1] = 8'(sent + 1);
         if (rd[1] && !b_empty) got.push_back(b_dout);
         if (wr[1]) sent++;
         tick();
      end
      chk("d5.received", got.size(), 20);
      for (int j = 0; j < got.size(); j++)
         chk($sformatf("d5.byte%0d", j), int'(got[j]), j + 1);
      idle_all();
      tick();

      // --- randomized traffic on all instances, with one mid-run reset ---
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < 3; i++) begin
            wr[i]  = ($urandom_range(99) < 60);
            rd[i]  = ($urandom_range(99) < 50);
            fl[i]  = ($urandom_range(99) < 3);
            clr[i] = ($urandom_range(99) < 4);
            di[i]  = 8'($urandom);
         end
         rst_n = !(k == 300);
         tick();
      end
      rst_n = 1'b1;
      idle_all();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_fwft_param.md
Name: fifo_fwft_param

Overview:
- Parametrised first-word-fall-through FIFO; next generation of the CRC peripheral's byte buffer.
- Sits between the TinyQV bus write path and the CRC32 engine.
- Adds over the 8x8 FIFO: configurable width/depth, non-power-of-2 depth, full-with-read write acceptance, synchronous flush, almost-full/almost-empty thresholds, free-space count, sticky overflow/underflow flags, high-water mark.

Parameters:
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 8, number of entries (>=2, any integer, not restricted to powers of 2)
- AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of contents and pointers
- wr_en  in  1  write request
- din  in  DATA_W  write data
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- rd_en  in  1  consume the head entry (advance)
- dout  out  DATA_W  head entry; all-zero when empty
- empty  out  1  count == 0
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CW  occupancy, CW = clog2(DEPTH+1)
- free  out  CW  DEPTH - count, combinational
- hwm  out  CW  high-water mark, maximum count since reset/clr_err
- overflow  out  1  sticky: write attempted while write was not accepted
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow, underflow and hwm

Behaviour:
- Reset (rst_n=0 at posedge):
  - wptr=rptr=count=0, hwm=0, overflow=underflow=0.
  - Outputs follow: empty=1, full=0, dout=0, free=DEPTH.
  - Memory contents are not reset.
- do_rd = rd_en & !empty.
- do_wr = wr_en & (!full | do_rd): a write while full is accepted when a read happens in the same cycle.
- Write: mem[wptr] <= din. wptr wraps DEPTH-1 -> 0 explicitly; DEPTH is not assumed to be a power of 2.
- Read: rptr wraps the same way.
- count updates:
  - +1 on write only
  - -1 on read only
  - unchanged on both or neither
  - never exceeds DEPTH, never below 0
- FWFT timing:
  - dout = mem[rptr] combinationally whenever !empty.
  - Data written into an empty FIFO appears on dout the cycle after the write; there is no same-cycle bypass.
  - A simultaneous rd_en and wr_en on an empty FIFO performs the write only and sets underflow.
- Status outputs (full, empty, almost_full, almost_empty, free) decode combinationally from the registered count.
- overflow is set when wr_en & !do_wr. underflow is set when rd_en & empty.
- hwm <= max(hwm, next_count) every cycle.
- flush (when rst_n=1):
  - Next state: wptr=rptr=count=0.
  - Any wr_en/rd_en in that cycle is discarded and does not set the flags.
  - overflow, underflow and hwm are not affected.
- clr_err:
  - Next state: overflow=underflow=0, hwm=next_count.
  - A set event in the same cycle wins (flag stays 1).
- Priority: rst_n > flush > normal operation.
- Reset or flush mid-stream drops all contents; dout is 0 in the following cycle.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function
  - a function computing CW from DEPTH
  - default DATA_W/DEPTH constants used by the CRC peripheral
- One natural sub-module, fifo_ptr_wrap: parametrised modulo-DEPTH pointer register with inc and clr inputs, instantiated twice (write and read pointers).

Test Plan:
- Reset then idle, DEPTH=8 -> empty=1, dout=0, count=0, free=8, flags 0.
- Write 0x11..0x88 (8 bytes) then one more write of 0x99 -> full=1, count=8, overflow=1, 0x99 dropped. Reads then return 0x11..0x88 in order; empty=1 after the 8th read.
- While full, rd_en=wr_en=1 with din=0xA5 -> count stays 8, dout advances to 0x22, and 0xA5 is read out last.
- DEPTH=5 (non-power-of-2) -> stream 20 bytes with interleaved reads; data order is preserved and pointers wrap 4->0 correctly.
- Empty FIFO, rd_en=1 -> underflow=1, count=0. Then clr_err -> underflow=0.
- Thresholds (AF_LEVEL=6, AE_LEVEL=2) and flush:
  - Fill to 6 -> almost_full=1, hwm=6.
  - flush with wr_en=1 in the same cycle -> next cycle count=0, empty=1, hwm still 6, overflow unchanged.
